spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 SHALL expose the ports: clk  in  1  system clock.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 data_write  in  16  bus write data; [15:8] upper byte, [7:0] lower byte.
REQ-005 data_read  out  16  bus read data, registered.
REQ-006 addr  in  8  bus address; block decodes addr[7:1]==0.
REQ-007 uds / lds  in  1 each  upper / lower byte strobe.
REQ-008 rw  in  1  1=read, 0=write.
REQ-009 ack  out  1  single-cycle access acknowledge.
REQ-010 spi_sclk / spi_mosi / spi_cs_n  in  1 each  asynchronous serial inputs from the external master.
REQ-011 spi_miso  out  1  serial data to master; spi_miso_oe  out  1  drive enable (high only while CS asserted).
REQ-012 irq  out  1  level interrupt = irq_en & (rx_valid | overrun).

Function
REQ-013 SHALL pass spi_sclk, spi_mosi, spi_cs_n through 2-flop synchronizers; edge detection on the synchronized values; SCLK period >= 8 clk.
REQ-014 SHALL operate in SPI mode 0: MOSI sampled on SCLK rising edge, MISO changed on SCLK falling edge, MSB first.
REQ-015 SHALL, on detected CS assertion, clear the 3-bit bit counter and load tx shift register from tx_hold if tx_full else 8'hFF, setting underrun in the 8'hFF case; MISO = shift[7] immediately.
REQ-016 SHALL shift MOSI into rx shift register on each rising edge and increment the bit counter (wraps 7->0).
REQ-017 SHALL, on the rising edge completing bit 7: rx_data <= completed byte, rx_valid <= 1; if rx_valid was already 1 and not being read that cycle, set overrun (new byte overwrites).
REQ-018 SHALL, on the first falling edge after a completed byte, reload tx shift per REQ-015 rules (tx_full cleared on load); otherwise shift left on falling edges.
REQ-019 SHALL, on CS deassertion mid-byte, discard the partial byte, clear the bit counter, not set rx_valid, drop spi_miso_oe.
REQ-020 SHALL decode registers only when addr[7:1]==0; other addresses give ack=0 and no side effects.
REQ-021 Read uds: data_read[15:8] <= rx_data, clears rx_valid; read lds: data_read[7:0] <= {0, irq_en, overrun, underrun, tx_full, rx_valid, cs_active, busy}.
REQ-022 Write uds: tx_hold <= data_write[15:8], tx_full <= 1; write lds: irq_en <= bit6, bit5=1 clears overrun, bit4=1 clears underrun.
REQ-023 SHALL assert ack for one cycle, registered, in the cycle after any decoded access with uds|lds; ack SHALL be 0 otherwise.
REQ-024 SHALL resolve simultaneity: RX read same cycle as byte completion returns old byte, rx_valid stays 1 with new byte, no overrun; TX write same cycle as shift reload loads old hold value and new write stays pending (tx_full=1).
REQ-025 busy = cs_active & bit counter != 0.

Reset
REQ-026 SHALL on reset clear: data_read=0, ack=0, rx_data=0, tx_hold=0, rx_valid, tx_full, overrun, underrun, irq_en=0, bit counter=0, synchronizers to idle (sclk 0, cs_n 1), spi_miso=0, spi_miso_oe=0, irq=0.
REQ-027 SHALL, on reset mid-transfer, abandon the byte and resume only at the next CS assertion.

Structure
REQ-028 Shared package spi_slave_pkg SHALL hold status bit positions, write-1-clear bit positions, and IDLE_TX_BYTE=8'hFF.
REQ-029 SHALL instantiate one sub-module sync2 (parameter width, 2-flop synchronizer) for the three SPI inputs.

Verification
REQ-030 Write tx_hold=8'hA5, master sends 8'h3C at clk/8 -> MISO bits 10100101, rx_data=8'h3C, rx_valid=1, tx_full=0, irq=1 if irq_en.
REQ-031 No TX write, master sends one byte -> MISO 8'hFF, underrun=1; lds write 8'h10 -> underrun=0.
REQ-032 Two bytes 8'h11, 8'h22 without RX read -> overrun=1, rx_data=8'h22; uds read returns 8'h22, rx_valid=0.
REQ-033 CS deasserted after 4 bits -> rx_valid unchanged, next full byte 8'h81 received correctly, spi_miso_oe=0 between.
REQ-034 RX read in same cycle as byte completion -> read returns previous byte, rx_valid=1, overrun=0.
REQ-035 Access with addr=8'h02 -> ack=0, no register change; reset asserted mid-byte -> all REQ-026 values.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: status/control bit positions and idle transmit byte shared by the SPI slave
package spi_slave_pkg;
    localparam int ST_BUSY      = 0;
    localparam int ST_CS_ACTIVE = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_TX_FULL   = 3;
    localparam int ST_UNDERRUN  = 4;
    localparam int ST_OVERRUN   = 5;
    localparam int ST_IRQ_EN    = 6;
    localparam int CTL_IRQ_EN   = 6;
    localparam int W1C_OVERRUN  = 5;
    localparam int W1C_UNDERRUN = 4;
    localparam logic [7:0] IDLE_TX_BYTE = 8'hFF;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: host bus, serial pins and interrupt of the SPI slave
interface spi_slave_if;
    logic [15:0] data_write;
    logic [15:0] data_read;
    logic [7:0]  addr;
    logic        uds;
    logic        lds;
    logic        rw;
    logic        ack;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        irq;
    modport master (
        output data_write, addr, uds, lds, rw, spi_sclk, spi_mosi, spi_cs_n,
        input  data_read, ack, spi_miso, spi_miso_oe, irq
    );
    modport slave (
        input  data_write, addr, uds, lds, rw, spi_sclk, spi_mosi, spi_cs_n,
        output data_read, ack, spi_miso, spi_miso_oe, irq
    );
endinterface

// File: rtl/sync2.sv
// sync2: two-flop synchronizer with a per-bit idle value held during reset
module sync2 #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    // two flops in series; the second one is the only one consumers may look at
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave with one-byte rx/tx holding registers on a 16-bit byte-strobed bus
module spi_slave
    import spi_slave_pkg::*;
(
    input logic        clk,
    input logic        reset,
    spi_slave_if.slave bus
);
    logic [2:0] spi_s;
    logic       sclk_s, mosi_s, cs_n_s, sclk_q, cs_n_q;
    logic       cs_active, cs_assert, cs_deassert, shift_rise, shift_fall;
    logic       sel, rd_rx, rd_st, wr_tx, wr_ctl, byte_done, load, busy;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte, tx_shift, rx_data, tx_hold, status;
    logic       rx_valid, tx_full, overrun, underrun, irq_en, reload_pend;
    logic       unused_bits;

    sync2 #(.WIDTH(3), .RST_VAL(3'b100)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({bus.spi_cs_n, bus.spi_mosi, bus.spi_sclk}),
        .q     (spi_s)
    );

    assign cs_n_s      = spi_s[2];
    assign mosi_s      = spi_s[1];
    assign sclk_s      = spi_s[0];
    assign cs_active   = ~cs_n_q;
    assign cs_assert   = ~cs_n_s & cs_n_q;
    assign cs_deassert = cs_n_s & ~cs_n_q;
    assign shift_rise  = sclk_s & ~sclk_q & cs_active & ~cs_n_s;
    assign shift_fall  = ~sclk_s & sclk_q & cs_active & ~cs_n_s;
    assign sel         = (bus.addr[7:1] == 7'd0) & (bus.uds | bus.lds);
    assign rd_rx       = sel & bus.rw & bus.uds;
    assign rd_st       = sel & bus.rw & bus.lds;
    assign wr_tx       = sel & ~bus.rw & bus.uds;
    assign wr_ctl      = sel & ~bus.rw & bus.lds;
    assign rx_byte     = {rx_shift, mosi_s};
    assign byte_done   = shift_rise & (bit_cnt == 3'd7);
    assign load        = cs_assert | (shift_fall & reload_pend);
    assign busy        = cs_active & (bit_cnt != 3'd0);
    assign bus.irq         = irq_en & (rx_valid | overrun);
    assign bus.spi_miso    = tx_shift[7];
    assign bus.spi_miso_oe = cs_active;
    assign unused_bits = ^{bus.data_write[7], bus.data_write[3:0], bus.addr[0]};

    // status byte as seen by a lower-byte read
    always_comb begin
        status               = '0;
        status[ST_BUSY]      = busy;
        status[ST_CS_ACTIVE] = cs_active;
        status[ST_RX_VALID]  = rx_valid;
        status[ST_TX_FULL]   = tx_full;
        status[ST_UNDERRUN]  = underrun;
        status[ST_OVERRUN]   = overrun;
        status[ST_IRQ_EN]    = irq_en;
    end

    // previous synchronized sclk / cs_n for edge detection
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            cs_n_q <= cs_n_s;
        end

    // bus registers and serial engine; later statements win so completion beats an rx read and a tx write beats a reload
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.data_read <= '0;
            bus.ack       <= 1'b0;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            rx_data       <= '0;
            tx_hold       <= '0;
            rx_valid      <= 1'b0;
            tx_full       <= 1'b0;
            overrun       <= 1'b0;
            underrun      <= 1'b0;
            irq_en        <= 1'b0;
            reload_pend   <= 1'b0;
        end else begin
            bus.ack <= sel;
            if (rd_rx) begin
                bus.data_read[15:8] <= rx_data;
                rx_valid            <= 1'b0;
            end
            if (rd_st) bus.data_read[7:0] <= status;
            if (wr_ctl) begin
                irq_en <= bus.data_write[CTL_IRQ_EN];
                if (bus.data_write[W1C_OVERRUN]) overrun <= 1'b0;
                if (bus.data_write[W1C_UNDERRUN]) underrun <= 1'b0;
            end
            if (cs_assert | cs_deassert) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end
            if (shift_rise) begin
                rx_shift <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
                rx_data     <= rx_byte;
                rx_valid    <= 1'b1;
                reload_pend <= 1'b1;
                if (rx_valid & ~rd_rx) overrun <= 1'b1;
            end
            if (shift_fall & ~reload_pend) tx_shift <= {tx_shift[6:0], 1'b0};
            if (load) begin
                tx_shift    <= tx_full ? tx_hold : IDLE_TX_BYTE;
                tx_full     <= 1'b0;
                reload_pend <= 1'b0;
                if (!tx_full) underrun <= 1'b1;
            end
            if (wr_tx) begin
                tx_hold <= bus.data_write[15:8];
                tx_full <= 1'b1;
            end
        end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: transaction-level model of the SPI slave registers checked against the DUT
module tb_spi_slave;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_slave_if bif();
    spi_slave dut (.clk(clk), .reset(reset), .bus(bif));

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    logic [7:0]  m_rx_data, m_tx_hold, m_cur_tx, g;
    logic        m_rx_valid, m_tx_full, m_ovr, m_und, m_irq_en, m_cs;
    logic [15:0] m_dr, v;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {1'b0, m_irq_en, m_ovr, m_und, m_tx_full, m_rx_valid, m_cs, 1'b0};
    endfunction

    task automatic model_reset();
        m_rx_data = '0; m_tx_hold = '0; m_cur_tx = '0; m_dr = '0;
        m_rx_valid = 0; m_tx_full = 0; m_ovr = 0; m_und = 0; m_irq_en = 0; m_cs = 0;
    endtask

    task automatic model_load();
        m_cur_tx = m_tx_full ? m_tx_hold : 8'hFF;
        if (!m_tx_full) m_und = 1;
        m_tx_full = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // every cycle the serial side is idle, irq, drive enable and the presented MISO bit must follow the model
    always @(negedge clk)
        if (chk_en && !reset) begin
            check("irq", bif.irq, m_irq_en & (m_rx_valid | m_ovr));
            check("miso_oe", bif.spi_miso_oe, m_cs);
            if (m_cs) check("miso_idle", bif.spi_miso, m_cur_tx[7]);
        end

    task automatic bus_cycle(input logic r, input logic [7:0] a, input logic u, input logic l,
                             input logic [15:0] dw, output logic [15:0] dr, output logic ak);
        bif.rw = r; bif.addr = a; bif.uds = u; bif.lds = l; bif.data_write = dw;
        cyc(1);
        bif.uds = 0; bif.lds = 0;
        ak = bif.ack; dr = bif.data_read;
        cyc(1);
        check("ack_single", bif.ack, 1'b0);
    endtask

    task automatic wr(input logic [7:0] a, input logic u, input logic l, input logic [15:0] dw);
        logic [15:0] dr;
        logic ak, dec;
        dec = (a[7:1] == 7'd0);
        chk_en = 0;
        bus_cycle(0, a, u, l, dw, dr, ak);
        check("wr_ack", ak, dec);
        check("wr_data_read", dr, m_dr);
        if (dec && u) begin m_tx_hold = dw[15:8]; m_tx_full = 1; end
        if (dec && l) begin
            m_irq_en = dw[6];
            if (dw[5]) m_ovr = 0;
            if (dw[4]) m_und = 0;
        end
        chk_en = 1;
    endtask

    task automatic rd(input logic [7:0] a, input logic u, input logic l, output logic [15:0] val);
        logic ak, dec;
        dec = (a[7:1] == 7'd0);
        chk_en = 0;
        if (dec && u) m_dr[15:8] = m_rx_data;
        if (dec && l) m_dr[7:0] = exp_status();
        bus_cycle(1, a, u, l, 16'h0, val, ak);
        check("rd_ack", ak, dec);
        check("rd_data", val, m_dr);
        if (dec && u) m_rx_valid = 0;
        chk_en = 1;
    endtask

    task automatic cs_on();
        chk_en = 0;
        bif.spi_cs_n = 0;
        cyc(4);
        model_load();
        m_cs = 1;
        chk_en = 1;
    endtask

    task automatic cs_off();
        chk_en = 0;
        bif.spi_cs_n = 1;
        cyc(4);
        m_cs = 0;
        chk_en = 1;
    endtask

    // op 1: rx read lands on the completing rising edge; op 2: tx write lands on the reload falling edge
    task automatic xfer(input logic [7:0] b, input int nbits, input int op, input logic [7:0] wv,
                        output logic [7:0] got);
        logic [15:0] dr;
        logic ak;
        logic [7:0] exp_tx;
        chk_en = 0;
        exp_tx = m_cur_tx;
        got = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            bif.spi_mosi = b[i];
            cyc(4);
            got[i] = bif.spi_miso;
            bif.spi_sclk = 1;
            if (i == 0 && op == 1) begin
                cyc(2);
                bus_cycle(1, 8'h00, 1, 0, 16'h0, dr, ak);
                check("sync_rd_ack", ak, 1'b1);
                check("sync_rd_old", dr[15:8], m_rx_data);
                m_dr[15:8] = m_rx_data;
            end else cyc(4);
            bif.spi_sclk = 0;
        end
        if (nbits == 8) begin
            check("miso_byte", got, exp_tx);
            if (m_rx_valid && op != 1) m_ovr = 1;
            m_rx_data = b;
            m_rx_valid = 1;
            if (op == 2) begin
                cyc(2);
                bus_cycle(0, 8'h00, 1, 0, {wv, 8'h00}, dr, ak);
                check("sync_wr_ack", ak, 1'b1);
            end else cyc(4);
            model_load();
            if (op == 2) begin m_tx_hold = wv; m_tx_full = 1; end
            chk_en = 1;
        end else cyc(4);
    endtask

    initial begin
        bif.data_write = '0; bif.addr = '0; bif.uds = 0; bif.lds = 0; bif.rw = 0;
        bif.spi_sclk = 0; bif.spi_mosi = 0; bif.spi_cs_n = 1;
        model_reset();
        cyc(2);
        check("rst_data_read", bif.data_read, 16'h0);
        check("rst_ack", bif.ack, 1'b0);
        check("rst_miso", bif.spi_miso, 1'b0);
        check("rst_miso_oe", bif.spi_miso_oe, 1'b0);
        check("rst_irq", bif.irq, 1'b0);
        reset = 0;
        cyc(3);
        chk_en = 1;
        rd(8'h00, 0, 1, v);
        check("lit_status_reset", v[7:0], 8'h00);

        // undecoded address: no ack, no effect
        wr(8'h02, 0, 1, 16'h0040);
        wr(8'h02, 1, 0, 16'h7700);
        rd(8'h02, 1, 1, v);
        rd(8'h00, 0, 1, v);
        check("lit_status_nodecode", v[7:0], 8'h00);

        // tx A5 out, 3C in, irq enabled; addr 01 also decodes
        wr(8'h01, 0, 1, 16'h0040);
        wr(8'h01, 1, 0, 16'hA500);
        rd(8'h00, 0, 1, v);
        check("lit_status_armed", v[7:0], 8'h48);
        cs_on();
        xfer(8'h3C, 8, 0, 8'h00, g);
        check("lit_miso_a5", g, 8'hA5);
        check("lit_irq_on", bif.irq, 1'b1);
        cs_off();
        rd(8'h00, 0, 1, v);
        check("lit_status_rx", v[7:0], 8'h54);
        rd(8'h00, 1, 0, v);
        check("lit_rx_3c", v[15:8], 8'h3C);

        // underrun without tx write, then clear it
        wr(8'h00, 0, 1, 16'h0010);
        cs_on();
        xfer(8'h5A, 8, 0, 8'h00, g);
        check("lit_miso_ff", g, 8'hFF);
        rd(8'h00, 0, 1, v);
        check("lit_status_und", v[7:0], 8'h16);
        wr(8'h00, 0, 1, 16'h0010);
        rd(8'h00, 0, 1, v);
        check("lit_status_und_clr", v[7:0], 8'h06);
        cs_off();
        rd(8'h00, 1, 0, v);
        check("lit_rx_5a", v[15:8], 8'h5A);

        // overrun: two bytes, no read between
        cs_on();
        xfer(8'h11, 8, 0, 8'h00, g);
        xfer(8'h22, 8, 0, 8'h00, g);
        rd(8'h00, 0, 1, v);
        check("lit_status_ovr", v[7:0], 8'h36);
        rd(8'h00, 1, 0, v);
        check("lit_rx_22", v[15:8], 8'h22);
        cs_off();
        wr(8'h00, 0, 1, 16'h0030);

        // partial byte discarded, next byte aligned
        cs_on();
        xfer(8'hF0, 4, 0, 8'h00, g);
        cs_off();
        check("lit_oe_between", bif.spi_miso_oe, 1'b0);
        rd(8'h00, 0, 1, v);
        check("lit_rxv_after_partial", v[2], 1'b0);
        cs_on();
        xfer(8'h81, 8, 0, 8'h00, g);
        cs_off();
        rd(8'h00, 1, 0, v);
        check("lit_rx_81", v[15:8], 8'h81);

        // rx read coinciding with byte completion
        wr(8'h00, 0, 1, 16'h0070);
        cs_on();
        xfer(8'h47, 8, 0, 8'h00, g);
        xfer(8'h99, 8, 1, 8'h00, g);
        check("lit_sync_rd_old", m_dr[15:8], 8'h47);
        rd(8'h00, 0, 1, v);
        check("lit_status_sync_rd", v[7:0], 8'h56);
        rd(8'h00, 1, 0, v);
        check("lit_rx_99", v[15:8], 8'h99);
        cs_off();

        // tx write coinciding with reload
        wr(8'h00, 0, 1, 16'h0070);
        wr(8'h00, 1, 0, 16'h1200);
        cs_on();
        wr(8'h00, 1, 0, 16'h3400);
        xfer(8'hAA, 8, 2, 8'h56, g);
        check("lit_miso_12", g, 8'h12);
        rd(8'h00, 0, 1, v);
        check("lit_txfull_pending", v[3], 1'b1);
        xfer(8'h0F, 8, 0, 8'h00, g);
        check("lit_miso_34", g, 8'h34);
        xfer(8'hF0, 8, 0, 8'h00, g);
        check("lit_miso_56", g, 8'h56);
        wr(8'h00, 1, 0, 16'h7700);

        // reset in the middle of a byte
        xfer(8'hE7, 3, 0, 8'h00, g);
        chk_en = 0;
        reset = 1;
        #1;
        check("mid_rst_data_read", bif.data_read, 16'h0);
        check("mid_rst_ack", bif.ack, 1'b0);
        check("mid_rst_miso", bif.spi_miso, 1'b0);
        check("mid_rst_miso_oe", bif.spi_miso_oe, 1'b0);
        check("mid_rst_irq", bif.irq, 1'b0);
        bif.spi_cs_n = 1;
        bif.spi_sclk = 0;
        cyc(3);
        reset = 0;
        model_reset();
        cyc(3);
        chk_en = 1;
        rd(8'h00, 0, 1, v);
        check("lit_status_mid_rst", v[7:0], 8'h00);
        rd(8'h00, 1, 0, v);
        check("lit_rx_mid_rst", v[15:8], 8'h00);
        cs_on();
        xfer(8'hC3, 8, 0, 8'h00, g);
        check("lit_miso_after_rst", g, 8'hFF);
        cs_off();
        rd(8'h00, 1, 0, v);
        check("lit_rx_c3", v[15:8], 8'hC3);

        chk_en = 0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
